// File: rtl/duursma_lee_loader.sv
// Word-serial operand loader for the Duursma-Lee pairing core: assembles xp/yp/xr/yr
// from 32-bit words, rejects illegal trit encodings, pulses start and waits for done.
module duursma_lee_loader #(
  parameter int WIDTH = 193,
  parameter int WORD  = 32,
  parameter int NW    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WORD-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             algo_done,
  output logic             start,
  output logic [WIDTH:0]   xp,
  output logic [WIDTH:0]   yp,
  output logic [WIDTH:0]   xr,
  output logic [WIDTH:0]   yr,
  output logic             err,
  output logic             busy
);

  localparam int WI = $clog2(NW);
  localparam logic [WI-1:0] LAST_WORD = WI'(NW - 1);

  typedef enum logic [1:0] {S_LOAD, S_CHECK, S_START, S_WAIT} state_t;

  state_t          state, state_next;
  logic [1:0]      op_idx;
  logic [WI-1:0]   word_idx;
  logic            bad;
  logic            done_q;
  logic [WIDTH:0]  ops [4];
  logic            accept;
  logic            last_word;
  logic            bad_word;
  int              base;

  assign accept    = in_valid && in_ready;
  assign last_word = (op_idx == 2'd3) && (word_idx == LAST_WORD);
  assign base      = int'(word_idx) * WORD;

  // A word is bad if a trit pair inside the operand reads 2'b11, or if any bit
  // that falls above the operand MSB (the padding of the last word) is set.
  always_comb begin
    // NOTE: combinational outputs get a default first so no path can infer a latch.
    bad_word = 1'b0;
    for (int i = 0; i < WORD / 2; i++) begin
      if ((base + 2 * i + 1 <= WIDTH) && (in_data[2*i +: 2] == 2'b11)) bad_word = 1'b1;
    end
    for (int k = 0; k < WORD; k++) begin
      if ((base + k > WIDTH) && in_data[k]) bad_word = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  if (accept && last_word) state_next = S_CHECK;
      S_CHECK: state_next = bad ? S_LOAD : S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (algo_done && !done_q) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_LOAD;
      op_idx   <= '0;
      word_idx <= '0;
      bad      <= 1'b0;
      done_q   <= 1'b0;
      // NOTE: the operand store drives the core directly, so it is cleared on reset
      // rather than left as an unreset memory.
      for (int k = 0; k < 4; k++) ops[k] <= '0;
    end else begin
      state  <= state_next;
      done_q <= algo_done;
      case (state)
        S_LOAD: begin
          if (accept) begin
            for (int b = 0; b <= WIDTH; b++) begin
              if (b / WORD == int'(word_idx)) ops[op_idx][b] <= in_data[b % WORD];
            end
            bad <= bad | bad_word;
            if (word_idx == LAST_WORD) begin
              word_idx <= '0;
              op_idx   <= op_idx + 2'd1;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        S_CHECK: begin
          bad      <= 1'b0;
          op_idx   <= '0;
          word_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_LOAD);
  assign start    = (state == S_START);
  assign err      = (state == S_CHECK) && bad;

  assign xp = ops[0];
  assign yp = ops[1];
  assign xr = ops[2];
  assign yr = ops[3];

endmodule

// File: tb/tb_duursma_lee_loader.sv
// Directed bench for duursma_lee_loader: frames are queued with their expected outcome
// and checked when start or err appears.
module tb_duursma_lee_loader;

  localparam int WIDTH  = 193;
  localparam int WORD   = 32;
  localparam int NW     = 7;
  localparam int NWORDS = 4 * NW;

  typedef logic [WORD-1:0] frame_t [NWORDS];
  typedef logic [3:0][WIDTH:0] opset_t;
  typedef struct {
    logic   bad;
    opset_t ops;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [WORD-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            algo_done;
  logic            start;
  logic [WIDTH:0]  xp, yp, xr, yr;
  logic            err;
  logic            busy;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb [$];

  duursma_lee_loader #(.WIDTH(WIDTH), .WORD(WORD), .NW(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .algo_done (algo_done),
    .start     (start),
    .xp        (xp),
    .yp        (yp),
    .xr        (xr),
    .yr        (yr),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk_frame(input opset_t ops);
    frame_t w;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < NW - 1; j++) w[NW*k + j] = ops[k][WORD*j +: WORD];
      w[NW*k + NW - 1] = {30'b0, ops[k][WIDTH -: 2]};
    end
    return w;
  endfunction

  // Operands the core should see for a given word stream (padding bits dropped).
  function automatic opset_t model_ops(input frame_t w);
    opset_t r;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < NW - 1; j++) r[k][WORD*j +: WORD] = w[NW*k + j];
      r[k][WIDTH -: 2] = w[NW*k + NW - 1][1:0];
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic put_word(input logic [WORD-1:0] w, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check1("in_ready_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t w, input bit gaps, input bit exp_bad, input int n_words);
    exp_t e;
    if (n_words == NWORDS) begin
      e.bad = exp_bad;
      e.ops = model_ops(w);
      sb.push_back(e);
    end
    for (int i = 0; i < n_words; i++) put_word(w[i], gaps && ($urandom_range(0, 1) == 1));
  endtask

  // Starts at the negedge right after the last word was accepted (the CHECK cycle).
  task automatic check_frame();
    exp_t e;
    int   n_s = 0, n_e = 0, t_s = -1, t_e = -1;
    logic rdy1 = 1'bx, busy1 = 1'bx, excl = 1'b0;
    if (sb.size() == 0) begin
      check1("sb_underflow", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (start) begin n_s++; if (t_s < 0) t_s = i; end
      if (err)   begin n_e++; if (t_e < 0) t_e = i; end
      if (start && err) excl = 1'b1;
      if (i == 1) begin rdy1 = in_ready; busy1 = busy; end
    end
    check1("start_err_excl", excl, 1'b0);
    checkw("xp", xp, e.ops[0]);
    checkw("yp", yp, e.ops[1]);
    checkw("xr", xr, e.ops[2]);
    checkw("yr", yr, e.ops[3]);
    if (e.bad) begin
      checki("err_pulses", n_e, 1);
      checki("err_time", t_e, 0);
      checki("start_pulses_bad", n_s, 0);
      check1("ready_after_err", rdy1, 1'b1);
      check1("busy_after_err", busy1, 1'b0);
    end else begin
      checki("start_pulses", n_s, 1);
      checki("start_time", t_s, 1);
      checki("err_pulses_good", n_e, 0);
      check1("ready_during_start", rdy1, 1'b0);
      check1("busy_during_start", busy1, 1'b1);
    end
  endtask

  task automatic pulse_done();
    check1("waiting_not_ready", in_ready, 1'b0);
    algo_done = 1'b1;
    @(negedge clk);
    check1("done_release", in_ready, 1'b1);
    check1("done_not_busy", busy, 1'b0);
    algo_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    checkw({tag, "_xp"}, xp, '0);
    checkw({tag, "_yp"}, yp, '0);
    checkw({tag, "_xr"}, xr, '0);
    checkw({tag, "_yr"}, yr, '0);
    check1({tag, "_start"}, start, 1'b0);
    check1({tag, "_err"}, err, 1'b0);
    check1({tag, "_ready"}, in_ready, 1'b1);
    check1({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    opset_t nom;
    frame_t f_nom, f;

    nom[0] = {2'b00, 192'haa5a8129a02a0544a4409a500045458901280969815aa820};
    nom[1] = {2'b01, 192'h414a205a21a4428968985650895464402249258428049204};
    nom[2] = {2'b00, 192'h614011499522506668a01a20988812468a5aa8641aa24595};
    nom[3] = {2'b00, 192'haa01145590659058124a0261410682860225909182a92189};
    f_nom  = mk_frame(nom);

    reset = 1'b0; in_valid = 1'b0; in_data = '0; algo_done = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    reset = 1'b1;
    @(negedge clk);

    // Nominal frame, in_valid held high.
    checki("word0", int'(f_nom[0]), int'(32'h815aa820));
    send_frame(f_nom, 1'b0, 1'b0, NWORDS);
    check_frame();
    repeat (3) @(negedge clk);
    check1("wait_holds", busy, 1'b1);
    pulse_done();

    // Same frame with random valid gaps.
    send_frame(f_nom, 1'b1, 1'b0, NWORDS);
    check_frame();
    pulse_done();

    // Illegal trit in word 3 of yp, then a clean frame.
    f = f_nom;
    f[NW + 3][1:0] = 2'b11;
    send_frame(f, 1'b0, 1'b1, NWORDS);
    check_frame();
    send_frame(f_nom, 1'b0, 1'b0, NWORDS);
    check_frame();
    pulse_done();

    // Nonzero padding in the last word of xr.
    f = f_nom;
    f[2*NW + NW - 1] = 32'h00000004;
    send_frame(f, 1'b0, 1'b1, NWORDS);
    check_frame();

    // Done held high from before the start pulse must not release WAIT.
    algo_done = 1'b1;
    send_frame(f_nom, 1'b0, 1'b0, NWORDS);
    check_frame();
    repeat (4) @(negedge clk);
    check1("held_done_wait", in_ready, 1'b0);
    algo_done = 1'b0;
    @(negedge clk);
    check1("done_low_wait", in_ready, 1'b0);
    algo_done = 1'b1;
    @(negedge clk);
    check1("done_rise_release", in_ready, 1'b1);
    algo_done = 1'b0;
    @(negedge clk);

    // Reset after word 10, then a full frame.
    send_frame(f_nom, 1'b0, 1'b0, 11);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("midreset");
    reset = 1'b1;
    @(negedge clk);
    send_frame(f_nom, 1'b0, 1'b0, NWORDS);
    check_frame();
    pulse_done();

    checki("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/duursma_lee_loader.md
Name: duursma_lee_loader

Overview:
- Word-serial operand loader directly upstream of the Duursma-Lee pairing core.
- Accepts the four GF(3^m) operands xp, yp, xr, yr as a stream of 32-bit words over a valid/ready handshake.
- Validates the 2-bit-per-trit encoding and holds the assembled operands stable on the core's inputs.
- Issues the one-cycle start pulse to the core's `reset` input, then blocks new input until the core reports done.

Parameters:
- WIDTH, 193: MSB index of one GF(3^m) operand (operand is WIDTH+1 = 194 bits, 97 trits).
- WORD, 32: input word width.
- NW, 7: words per operand, ceil((WIDTH+1)/WORD).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  WORD  operand word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a word.
- algo_done  input  1  core's done output.
- start  output  1  one-cycle pulse, wired to the core's reset/start input.
- xp, yp, xr, yr  output  WIDTH+1 each  assembled operands to the core.
- err  output  1  one-cycle pulse when a frame is rejected.
- busy  output  1  high whenever the loader is not in LOAD.

Behaviour:
- Reset (reset==0 at a clk edge): state=LOAD, word counter=0, bad flag=0; xp/yp/xr/yr=0; start=0; err=0; done_q=0. Reset takes effect from any state, including mid-frame and during WAIT; a partial frame is discarded.
- Frame: 4*NW = 28 words, in the order xp, yp, xr, yr. Within each operand the least-significant word comes first: word j supplies bits [32j+31:32j].
- Acceptance: a word is accepted on an edge where in_valid && in_ready. in_ready = (state==LOAD). in_valid gaps are allowed; the counter only advances on acceptance.
- Each accepted word is written into its slot of the operand selected by counter/NW, word counter%NW. Outputs change only in LOAD.
- Trit check on every accepted word: any 2-bit pair at bits [2i+1:2i] equal to 2'b11 within operand bits 0..193 sets the bad flag (sticky until the frame ends). Encoding: 00=0, 01=1, 10=2.
- Padding check: in word NW-1 of each operand, bits [31:2] (operand bits 194..223) must be 0; otherwise the bad flag is set.
- States:
  - LOAD: acceptance of word 27 -> CHECK.
  - CHECK (1 cycle): if bad, err=1 for this cycle, counter=0, bad=0 -> LOAD (operands are left holding the partial or garbage values). Otherwise -> START.
  - START (1 cycle): start=1 -> WAIT.
  - WAIT: done_q is registered from algo_done each cycle. Exit to LOAD with counter=0 on the first cycle with algo_done==1 && done_q==0 (rising edge). A level-high done left over from a previous run does not release WAIT.
- Latency: last word accepted at edge k; CHECK occupies cycle k..k+1; start is high in the cycle following edge k+1. in_ready returns 1 the cycle after the done rising edge is seen.
- busy = (state != LOAD). err and start are never high in the same cycle.
- Simultaneous events: in_valid while not in LOAD is ignored (in_ready=0). A done edge arriving during LOAD, CHECK or START is ignored, though done_q still tracks it.

Test Plan:
- Nominal frame:
  - Stimulus: stream xp=194'haa5a8129a02a0544a4409a500045458901280969815aa820 (word0=32'h815aa820), yp=194'h1414a205a21a4428968985650895464402249258428049204, xr=194'h614011499522506668a01a20988812468a5aa8641aa24595, yr=194'haa01145590659058124a0261410682860225909182a92189, with in_valid always 1.
  - Response: outputs equal the inputs bit-exact; start high exactly 1 cycle, 2 edges after word 27; busy=1; in_ready=0 until a done pulse from a model core.
- Backpressure: same frame with random in_valid gaps (≈50% duty) -> identical outputs and one start pulse; word count unaffected by gaps.
- Illegal trit: word 3 of yp with bits [1:0]=2'b11 -> no start; err pulses 1 cycle after word 27; in_ready=1 the following cycle. A subsequent clean frame is accepted and starts normally.
- Bad padding: last word of xr=32'h00000004 (bit 2 set) -> err pulse, no start.
- Done handling: hold algo_done=1 throughout START and WAIT -> loader stays in WAIT. Drop algo_done to 0, then raise it to 1 -> in_ready=1 one cycle later.
- Reset mid-load: drive reset=0 for 1 cycle after word 10 -> all outputs 0, counter 0. A full 28-word frame then produces exactly one start pulse.
